pe_flit_injector: RTL and testbench
===================================

# pe_flit_injector

PE-side network injector feeding a mesh switch's PE input port (`i_data_pe`/`i_valid_pe`/`o_ready_pe`). It accepts one neuron output word and emits one flit per configured destination, so a layer output can be fanned out to every neuron of the next layer. Destinations are taken in a fixed order from a packed parameter list. It is the transmit end of the switch PE handshake and holds each flit stable until the switch accepts it.

## Interface
- `x_coord`, default 'd1: own switch X coordinate, inserted as source X.
- `y_coord`, default 'd1: own switch Y coordinate, inserted as source Y.
- `x_size`, default 2: X coordinate field width.
- `y_size`, default 2: Y coordinate field width.
- `data_width`, default 8: payload width.
- `total_width`, default 2*x_size+2*y_size+data_width: flit width.
- `num_dest`, default 4: number of destinations per word; must be ≥1.
- `dest_list`, default {2'd2,2'd3, 2'd2,2'd2, 2'd2,2'd1, 2'd2,2'd0}: packed list of num_dest*(x_size+y_size) bits. Entry k is `{dx,dy}` at bits [(k+1)*(x_size+y_size)-1 : k*(x_size+y_size)], and entry 0 is sent first.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `i_data`  in  data_width: neuron output word.
- `i_valid`  in  1: i_data is valid.
- `o_ready`  out  1: injector can accept i_data this cycle.
- `o_flit`  out  total_width: flit to the switch, connected to i_data_pe.
- `o_valid`  out  1: o_flit is valid, connected to i_valid_pe.
- `i_ready`  in  1: switch accepts the flit, connected to o_ready_pe.
- `o_done`  out  1: one-cycle pulse when the last flit of a word is accepted.

## Operation
- Flit layout, MSB to LSB: `{data, src_x, src_y, dst_x, dst_y}`. dst_y occupies [y_size-1:0] and dst_x occupies [x_size+y_size-1:y_size].
- Registers:
  - `word`: the captured payload.
  - `idx`: destination index, width clog2(num_dest), minimum 1.
  - `state`: IDLE or SEND.
- Input accept: i_valid & o_ready. Flit transfer: o_valid & i_ready.
- IDLE:
  - o_ready=1 and o_valid=0.
  - On input accept: word←i_data, idx←0, move to SEND.
- SEND:
  - o_valid=1 and o_flit={word, x_coord, y_coord, dest_list[idx]}.
  - On transfer with idx<num_dest-1: idx←idx+1.
  - On transfer with idx=num_dest-1: pulse o_done and return to IDLE.
  - Without transfer: hold o_flit and idx unchanged. Stalls have no limit.
- o_ready is decoded from registered state only. There is no combinational path from i_ready or i_valid to any output.
- o_flit is a function of registers only and is stable for the whole time o_valid is high.
- If i_valid is high while o_ready is low, the input is ignored. The neuron must hold its data.
- num_dest=1: each word produces exactly one flit.
- Destinations equal to own coordinates are sent normally; the switch performs the loopback.
- Reset values: state=IDLE, idx=0, o_valid=0, o_done=0, o_ready=1 (combinational from IDLE), word=0.
- Reset during SEND discards the word and any flits not yet sent.

## Timing
- Input accepted at edge N: o_valid is high in cycle N+1 with entry 0.
- With i_ready held high, flit k is transferred in cycle N+1+k.
- o_done is high in the cycle after the last transfer edge. o_ready returns high in that same cycle.
- Without the buffer, the minimum spacing between accepted words is num_dest+1 cycles.
- A stall cycle (i_ready=0) delays every remaining flit by one cycle.

## Configuration
- `INJ_INPUT_BUF_EN` defined: adds a one-entry input buffer, `buf`/`buf_vld`.
  - o_ready = ~buf_vld in both states.
  - In SEND, an input accept writes buf.
  - At the last transfer:
    - If buf_vld: word←buf, buf_vld←0, idx←0, stay in SEND.
    - Else if an input accept occurs in the same cycle: word←i_data directly, idx←0, stay in SEND.
    - Otherwise go to IDLE.
  - Back-to-back words then run with no idle cycle: minimum spacing is num_dest cycles.
  - buf_vld resets to 0.
- `INJ_INPUT_BUF_EN` not defined: no buffer, and o_ready is low throughout SEND.

## Test plan
- Reset, then i_data=8'hA5 with i_ready=1 and the default list → flits 16'hA558, 16'hA559, 16'hA55A, 16'hA55B on consecutive cycles. o_done pulses once. o_ready is low for 4 cycles.
- Same stimulus with i_ready=0 for 3 cycles on the second flit → 16'hA559 is held stable for 4 cycles. No flit is duplicated or lost, and the order is unchanged.
- i_valid held high with 8'h11, then 8'h22, during SEND without the macro → only 8'h11 is sent. 8'h22 is taken when o_ready rises, and its first flit is 16'h2258.
- With `INJ_INPUT_BUF_EN`, words 8'h11 and 8'h22 back-to-back with i_ready=1 → 8 flits in 8 consecutive cycles with no o_valid gap. A third word is refused while buf_vld=1.
- rst asserted while the third flit is pending → next cycle o_valid=0, o_ready=1, o_done=0. A new word 8'h3C restarts at 16'h3C58.
- num_dest=1, dest_list={2'd1,2'd1}, i_data=8'hFF → a single flit 16'hFF55 followed by o_done.

Source files
------------

// File: rtl/pe_flit_injector_if.sv
// pe_flit_injector_if: neuron-side word handshake plus switch-side flit handshake
// of the PE injector; master drives words and flit-ready, slave is the injector.
interface pe_flit_injector_if #(
    parameter int data_width  = 8,
    parameter int total_width = 16
);
    logic [data_width-1:0]  i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic [total_width-1:0] o_flit;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_done;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_flit, o_valid, o_done
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_flit, o_valid, o_done
    );
endinterface

// File: rtl/pe_flit_injector.sv
// pe_flit_injector: captures one neuron word and emits one flit per entry of dest_list.
// Optional macro INJ_INPUT_BUF_EN adds a one-entry input buffer for back-to-back words.
module pe_flit_injector #(
    parameter int                     x_size      = 2,
    parameter int                     y_size      = 2,
    parameter logic [x_size-1:0]      x_coord     = x_size'(1),
    parameter logic [y_size-1:0]      y_coord     = y_size'(1),
    parameter int                     data_width  = 8,
    parameter int                     total_width = 2*x_size + 2*y_size + data_width,
    parameter int                     num_dest    = 4,
    parameter logic [num_dest*(x_size+y_size)-1:0] dest_list =
        {2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0}
) (
    input logic               clk,
    input logic               rst,
    pe_flit_injector_if.slave bus
);

    localparam int ent_w = x_size + y_size;
    localparam int idx_w = (num_dest > 1) ? $clog2(num_dest) : 1;
    localparam logic [idx_w-1:0] IDX_ZERO = {idx_w{1'b0}};
    localparam logic [idx_w-1:0] IDX_ONE  = idx_w'(1);
    localparam logic [idx_w-1:0] IDX_LAST = idx_w'(num_dest - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                  state_r;
    logic [data_width-1:0]   word_r;
    logic [idx_w-1:0]        idx_r;
    logic                    valid_r;
    logic                    done_r;
    logic                    ready_s;
    logic                    acc_s;
    logic                    xfer_s;
    logic                    last_s;
    logic [ent_w-1:0]        dest_tbl_s [num_dest];
`ifdef INJ_INPUT_BUF_EN
    logic [data_width-1:0]   buf_r;
    logic                    buf_vld_r;
`endif

    for (genvar g = 0; g < num_dest; g++) begin : g_dest
        assign dest_tbl_s[g] = dest_list[g*ent_w +: ent_w];
    end

    // Input-side readiness, decoded purely from registers
    always_comb begin
        ready_s = 1'b0;
`ifdef INJ_INPUT_BUF_EN
        if (buf_vld_r) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
`else
        if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
`endif
    end

    assign acc_s  = bus.i_valid & ready_s;
    assign xfer_s = valid_r & bus.i_ready;
    assign last_s = (idx_r == IDX_LAST);

    // Injector FSM: capture word, walk the destination list, pulse done on the last flit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            word_r    <= {data_width{1'b0}};
            idx_r     <= IDX_ZERO;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
`ifdef INJ_INPUT_BUF_EN
            buf_r     <= {data_width{1'b0}};
            buf_vld_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (acc_s) begin
                        word_r  <= bus.i_data;
                        idx_r   <= IDX_ZERO;
                        state_r <= SEND;
                        valid_r <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer_s) begin
                        if (!last_s) begin
                            idx_r <= idx_r + IDX_ONE;
                        end else begin
                            done_r <= 1'b1;
                            idx_r  <= IDX_ZERO;
`ifdef INJ_INPUT_BUF_EN
                            // A buffered word takes precedence; else a same-cycle word goes straight in
                            if (buf_vld_r) begin
                                word_r    <= buf_r;
                                buf_vld_r <= 1'b0;
                            end else if (acc_s) begin
                                word_r <= bus.i_data;
                            end else begin
                                state_r <= IDLE;
                                valid_r <= 1'b0;
                            end
`else
                            state_r <= IDLE;
                            valid_r <= 1'b0;
`endif
                        end
                    end
`ifdef INJ_INPUT_BUF_EN
                    if (acc_s && !(xfer_s && last_s)) begin
                        buf_r     <= bus.i_data;
                        buf_vld_r <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= IDX_ZERO;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_s;
    assign bus.o_valid = valid_r;
    assign bus.o_done  = done_r;
    assign bus.o_flit  = {word_r, x_coord, y_coord, dest_tbl_s[idx_r]};

endmodule

// File: tb/tb_pe_flit_injector.sv
// tb_pe_flit_injector: randomized scoreboard bench for the PE flit injector, with a
// second single-destination instance.
module tb_pe_flit_injector;

    localparam int ND = 4;
`ifdef INJ_INPUT_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] flit;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_flit_injector_if #(.data_width(8), .total_width(16)) bus  ();
    pe_flit_injector_if #(.data_width(8), .total_width(16)) bus1 ();

    pe_flit_injector dut (.clk(clk), .rst(rst), .bus(bus));
    pe_flit_injector #(.num_dest(1), .dest_list(4'b0101)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t sb1_q[$];
    int   outstanding = 0;
    int   out1 = 0;
    int   xfer_cnt = 0;
    int   acc_cnt = 0;
    int   acc1_cnt = 0;
    bit   done_exp = 1'b0;
    bit   done1_exp = 1'b0;
    bit   mon_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_flit = 16'h0000;
    bit   rdy_rand = 1'b0;
    int   stall_at = -1;
    int   stall_done_at = -1;
    int   stall_left = 0;
    logic [3:0] dests [ND] = '{4'h8, 4'h9, 4'hA, 4'hB};
    logic ready_e, ready1_e, xfer, acc, xfer1, acc1;
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: predicts handshakes from flit counts, compares at negedge
    always @(negedge clk) begin
        if (mon_en) begin
            ready_e  = BUF_EN ? (outstanding <= ND) : (outstanding == 0);
            ready1_e = BUF_EN ? (out1 <= 1) : (out1 == 0);
            check("o_ready", bus.o_ready, ready_e);
            check("o_valid", bus.o_valid, outstanding > 0);
            check("o_done", bus.o_done, done_exp);
            check("o_ready_nd1", bus1.o_ready, ready1_e);
            check("o_valid_nd1", bus1.o_valid, out1 > 0);
            check("o_done_nd1", bus1.o_done, done1_exp);
            if (prev_stall) check("flit_hold", bus.o_flit, prev_flit);

            xfer = (outstanding > 0) && bus.i_ready;
            acc  = bus.i_valid && ready_e;
            prev_stall = (outstanding > 0) && !bus.i_ready;
            prev_flit  = bus.o_flit;
            done_exp   = 1'b0;
            if (xfer) begin
                if (sb_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL flit_extra actual=%0h expected=none", bus.o_flit);
                end else begin
                    e = sb_q.pop_front();
                    check("flit", bus.o_flit, e.flit);
                    done_exp = e.last;
                end
                outstanding--;
                xfer_cnt++;
            end
            if (acc) begin
                for (int k = 0; k < ND; k++)
                    sb_q.push_back('{flit: {bus.i_data, 2'd1, 2'd1, dests[k]}, last: (k == ND-1)});
                outstanding += ND;
                acc_cnt++;
            end

            xfer1 = (out1 > 0) && bus1.i_ready;
            acc1  = bus1.i_valid && ready1_e;
            done1_exp = 1'b0;
            if (xfer1) begin
                if (sb1_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL flit_nd1_extra actual=%0h expected=none", bus1.o_flit);
                end else begin
                    e = sb1_q.pop_front();
                    check("flit_nd1", bus1.o_flit, e.flit);
                    done1_exp = e.last;
                end
                out1--;
            end
            if (acc1) begin
                sb1_q.push_back('{flit: {bus1.i_data, 2'd1, 2'd1, 2'd1, 2'd1}, last: 1'b1});
                out1++;
                acc1_cnt++;
            end

            if (rst) begin
                sb_q.delete(); sb1_q.delete();
                outstanding = 0; out1 = 0;
                done_exp = 1'b0; done1_exp = 1'b0; prev_stall = 1'b0;
            end
        end
    end

    // Flit-side ready: all-ones, random, or a 3-cycle stall on a chosen flit
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            bus.i_ready = 1'b0;
            stall_left--;
        end else if (stall_at >= 0 && xfer_cnt == stall_at && stall_done_at != stall_at) begin
            bus.i_ready   = 1'b0;
            stall_left    = 2;
            stall_done_at = stall_at;
        end else if (rdy_rand) begin
            bus.i_ready = ($urandom_range(0, 3) != 0);
        end else begin
            bus.i_ready = 1'b1;
        end
    end

    task automatic send(input logic [7:0] d);
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        while (acc_cnt == start && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (acc_cnt == start) begin
            errors++;
            $display("FAIL accept_timeout actual=not_accepted expected=accepted data=%0h", d);
        end
    endtask

    task automatic send1(input logic [7:0] d);
        int start;
        int n;
        start = acc1_cnt;
        n = 0;
        bus1.i_data  = d;
        bus1.i_valid = 1'b1;
        while (acc1_cnt == start && n < 300) begin
            @(posedge clk); #1; n++;
        end
        bus1.i_valid = 1'b0;
        checks++;
        if (acc1_cnt == start) begin
            errors++;
            $display("FAIL accept_nd1_timeout actual=not_accepted expected=accepted data=%0h", d);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.i_valid = 1'b0;
        while ((outstanding != 0 || out1 != 0) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (outstanding != 0 || out1 != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d/%0d expected=0/0", outstanding, out1);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] d;
        bus.i_data = 8'h00; bus.i_valid = 1'b0;
        bus1.i_data = 8'h00; bus1.i_valid = 1'b0; bus1.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        send(8'hA5); drain();

        stall_at = xfer_cnt + 1;
        send(8'hA5); drain();

        send(8'h11); send(8'h22); send(8'h33); drain();

        send1(8'hFF); drain();

        // reset while the third flit of a word is pending
        base = xfer_cnt;
        send(8'hA5);
        bus.i_valid = 1'b0;
        n = 0;
        while (xfer_cnt < base + 2 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (xfer_cnt < base + 2) begin
            errors++;
            $display("FAIL reset_setup_timeout actual=%0d expected=%0d", xfer_cnt - base, 2);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'h3C); drain();

        rdy_rand = 1'b1;
        for (int w = 0; w < 30; w++) begin
            d = 8'($urandom_range(0, 255));
            send(d);
            if ($urandom_range(0, 1) == 0) begin
                bus.i_valid = 1'b0;
                repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            end
        end
        for (int w = 0; w < 4; w++) send1(8'($urandom_range(0, 255)));
        drain();
        rdy_rand = 1'b0;

        check("sb_empty", sb_q.size(), 0);
        check("sb1_empty", sb1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
